io_port_bank: RTL and testbench

Parametrised general-purpose I/O bank: the next-generation replacement for the fixed single-output/single-input port pair on the microcontroller data bus. It provides NUM_PORTS ports, each DATA_W bits wide, with per-bit direction control, input synchronisation, edge-triggered interrupt capture and a registered read path. The block sits on the internal bus as an indexed slave, alongside the register file, and drives one aggregated interrupt line to the control FSMs.

---
 rtl/io_port_pkg.sv | 17 +
 rtl/io_sync_edge.sv | 36 +++
 rtl/io_port_bank.sv | 130 +++++++++++++
 tb/tb_io_port_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// Shared register map and address-width helper for the GPIO bank.
package io_port_pkg;

    localparam int unsigned REG_OFF_W = 3;

    localparam logic [REG_OFF_W-1:0] OFF_OUT  = 3'd0;
    localparam logic [REG_OFF_W-1:0] OFF_DIR  = 3'd1;
    localparam logic [REG_OFF_W-1:0] OFF_PIN  = 3'd2;
    localparam logic [REG_OFF_W-1:0] OFF_IE   = 3'd3;
    localparam logic [REG_OFF_W-1:0] OFF_PEND = 3'd4;
    localparam logic [REG_OFF_W-1:0] OFF_EDGE = 3'd5;

    function automatic int unsigned addr_width(input int unsigned num_ports);
        return unsigned'($clog2(num_ports)) + REG_OFF_W;
    endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Per-port input synchroniser with one-cycle delayed copy for rise/fall detection.
module io_sync_edge #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pin_i,
    output logic [DATA_W-1:0] sync_o,
    output logic [DATA_W-1:0] rise_o,
    output logic [DATA_W-1:0] fall_o
);

    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] dly_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            dly_q <= '0;
        end else begin
            sync_q[0] <= pin_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/io_port_bank.sv
// Indexed GPIO bank: per-port OUT/DIR/IE/PEND/EDGE registers, synchronised PIN,
// registered read path and aggregated registered interrupt.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = addr_width(NUM_PORTS)
) (
    input  logic                        clk_i,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           addr_i,
    input  logic                        wr_en_i,
    input  logic                        rd_en_i,
    input  logic [DATA_W-1:0]           wdata_i,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        rd_valid_o,
    input  logic [NUM_PORTS*DATA_W-1:0] pin_in_i,
    output logic [NUM_PORTS*DATA_W-1:0] pin_out_o,
    output logic [NUM_PORTS*DATA_W-1:0] pin_oe_o,
    output logic                        irq_o
);

    logic [DATA_W-1:0] out_q  [NUM_PORTS];
    logic [DATA_W-1:0] dir_q  [NUM_PORTS];
    logic [DATA_W-1:0] ie_q   [NUM_PORTS];
    logic [DATA_W-1:0] pend_q [NUM_PORTS];
    logic [DATA_W-1:0] pend_d [NUM_PORTS];
    logic [DATA_W-1:0] edge_q [NUM_PORTS];
    logic [DATA_W-1:0] sync_v [NUM_PORTS];
    logic [DATA_W-1:0] rise   [NUM_PORTS];
    logic [DATA_W-1:0] fall   [NUM_PORTS];

    logic [REG_OFF_W-1:0] off;
    int unsigned          port_idx;
    logic                 wr_ok;
    logic [DATA_W-1:0]    rd_val;
    logic [DATA_W-1:0]    rdata_q;
    logic                 rd_valid_q;
    logic                 irq_d, irq_q;

    always_comb begin
        off      = addr_i[REG_OFF_W-1:0];
        port_idx = 32'(addr_i) >> REG_OFF_W;
        wr_ok    = wr_en_i && (port_idx < NUM_PORTS);
    end

    for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_port
        io_sync_edge #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk_i  (clk_i),
            .rst_n  (rst_n),
            .pin_i  (pin_in_i[g*DATA_W +: DATA_W]),
            .sync_o (sync_v[g]),
            .rise_o (rise[g]),
            .fall_o (fall[g])
        );
        assign pin_out_o[g*DATA_W +: DATA_W] = out_q[g];
        assign pin_oe_o[g*DATA_W +: DATA_W]  = dir_q[g];
    end

    // Clear first, then OR in new events so a same-cycle event wins over W1C.
    always_comb begin
        irq_d = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            pend_d[p] = pend_q[p];
            if (wr_ok && port_idx == p && off == OFF_PEND) begin
                pend_d[p] = pend_d[p] & ~wdata_i;
            end
            pend_d[p] = pend_d[p] | (edge_q[p] & rise[p]) | (~edge_q[p] & fall[p]);
            irq_d     = irq_d | (|(pend_q[p] & ie_q[p]));
        end
    end

    always_comb begin
        rd_val = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (port_idx == p) begin
                case (off)
                    OFF_OUT:  rd_val = out_q[p];
                    OFF_DIR:  rd_val = dir_q[p];
                    OFF_PIN:  rd_val = sync_v[p];
                    OFF_IE:   rd_val = ie_q[p];
                    OFF_PEND: rd_val = pend_q[p];
                    OFF_EDGE: rd_val = edge_q[p];
                    default:  rd_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                out_q[p]  <= '0;
                dir_q[p]  <= '0;
                ie_q[p]   <= '0;
                pend_q[p] <= '0;
                edge_q[p] <= '0;
            end
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                pend_q[p] <= pend_d[p];
                if (wr_ok && port_idx == p) begin
                    case (off)
                        OFF_OUT:  out_q[p]  <= wdata_i;
                        OFF_DIR:  dir_q[p]  <= wdata_i;
                        OFF_IE:   ie_q[p]   <= wdata_i;
                        OFF_EDGE: edge_q[p] <= wdata_i;
                        default:  ;
                    endcase
                end
            end
            rd_valid_q <= rd_en_i;
            rdata_q    <= rd_en_i ? rd_val : '0;
            irq_q      <= irq_d;
        end
    end

    assign rdata_o    = rdata_q;
    assign rd_valid_o = rd_valid_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: table-driven bus vectors with a read scoreboard,
// plus hand-written edge/interrupt/collision/reset sequences.
module tb_io_port_bank;

    localparam int unsigned NP = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = io_port_pkg::addr_width(NP);
    localparam int unsigned PW = NP * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic          wr_en, rd_en;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rd_valid;
    logic [PW-1:0] pin_in, pin_out, pin_oe;
    logic          irq;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs [$];

    io_port_bank #(
        .DATA_W      (DW),
        .NUM_PORTS   (NP),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i      (clk),
        .rst_n      (rst_n),
        .addr_i     (addr),
        .wr_en_i    (wr_en),
        .rd_en_i    (rd_en),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .rd_valid_o (rd_valid),
        .pin_in_i   (pin_in),
        .pin_out_o  (pin_out),
        .pin_oe_o   (pin_oe),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] ra(input int unsigned port, input int unsigned off);
        return AW'(port * 8 + off);
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic bus_op(input logic wr, input logic rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp);
        wr_en = wr;
        rd_en = rd;
        addr  = a;
        wdata = wd;
        if (rd) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic add(input logic wr, input logic rd, input int unsigned port,
                       input int unsigned off, input logic [DW-1:0] wd, input logic [DW-1:0] exp);
        vec_t v;
        v.wr = wr; v.rd = rd; v.a = ra(port, off); v.wd = wd; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rd_valid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", {{(PW-1){1'b0}}, rd_valid}, '0);
            end else begin
                check("rdata", PW'(rdata), PW'(exp_q.pop_front()));
            end
        end else begin
            check("rdata_idle_zero", PW'(rdata), '0);
        end
    end

    initial begin
        rst_n = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0; pin_in = '0;
        #2;
        check("reset_rdata", PW'(rdata), '0);
        check("reset_rd_valid", PW'(rd_valid), '0);
        check("reset_irq", PW'(irq), '0);
        check("reset_pin_out", pin_out, '0);
        check("reset_pin_oe", pin_oe, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        add(1, 0, 1, 0, 16'hA5A5, 0);
        add(1, 0, 1, 1, 16'hFF00, 0);
        add(0, 1, 1, 0, 0, 16'hA5A5);
        add(0, 1, 1, 1, 0, 16'hFF00);
        add(1, 0, 1, 2, 16'h1234, 0);
        add(0, 1, 1, 2, 0, 16'h0000);
        add(1, 0, 1, 4, 16'hFFFF, 0);
        add(0, 1, 1, 4, 0, 16'h0000);
        add(1, 0, 3, 0, 16'hFFFF, 0);
        add(0, 1, 3, 0, 0, 16'h0000);
        add(1, 0, 0, 6, 16'hFFFF, 0);
        add(0, 1, 0, 6, 0, 16'h0000);
        add(0, 1, 0, 7, 0, 16'h0000);
        add(1, 0, 2, 3, 16'h00FF, 0);
        add(0, 1, 2, 3, 0, 16'h00FF);
        add(1, 0, 2, 5, 16'h0F0F, 0);
        add(0, 1, 2, 5, 0, 16'h0F0F);
        add(0, 1, 1, 0, 0, 16'hA5A5);
        for (int i = 0; i < vecs.size(); i++) begin
            bus_op(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].wd, vecs[i].exp);
            if (i == 1) begin
                check("pin_out_port1", pin_out, 48'h0000_A5A5_0000);
                check("pin_oe_port1", pin_oe, 48'h0000_FF00_0000);
            end
        end
        check("pin_out_after_table", pin_out, 48'h0000_A5A5_0000);
        check("pin_oe_after_table", pin_oe, 48'h0000_FF00_0000);

        // Rising edge on bit0: PEND at 3rd edge, irq at 4th, W1C drops irq 2 edges on.
        bus_op(1, 0, ra(0, 5), 16'hFFFF, 0);
        bus_op(1, 0, ra(0, 3), 16'h0001, 0);
        pin_in[0] = 1'b1;
        cycles(3);
        check("rise_irq_not_yet", PW'(irq), '0);
        cycles(1);
        check("rise_irq_set", PW'(irq), 1);
        bus_op(0, 1, ra(0, 4), 0, 16'h0001);
        bus_op(1, 0, ra(0, 4), 16'h0001, 0);
        check("w1c_irq_still_high", PW'(irq), 1);
        cycles(1);
        check("w1c_irq_low", PW'(irq), '0);

        // Falling edge on bit5 with IE off: PEND sets, irq only after IE enabled.
        pin_in[5] = 1'b1;
        cycles(4);
        bus_op(1, 0, ra(0, 4), 16'h0020, 0);
        bus_op(1, 0, ra(0, 5), 16'hFFDF, 0);
        bus_op(1, 0, ra(0, 3), 16'h0000, 0);
        pin_in[5] = 1'b0;
        cycles(4);
        bus_op(0, 1, ra(0, 4), 0, 16'h0020);
        check("fall_irq_masked", PW'(irq), '0);
        bus_op(1, 0, ra(0, 3), 16'h0020, 0);
        check("ie_irq_not_yet", PW'(irq), '0);
        cycles(1);
        check("ie_irq_set", PW'(irq), 1);

        // W1C of bit3 lands on the same edge as its rising event.
        pin_in[3] = 1'b1;
        cycles(2);
        bus_op(1, 0, ra(0, 4), 16'h0008, 0);
        bus_op(0, 1, ra(0, 4), 0, 16'h0028);
        bus_op(1, 0, ra(0, 4), 16'h0008, 0);
        bus_op(0, 1, ra(0, 4), 0, 16'h0020);

        // Same-cycle read and write returns the pre-write value.
        bus_op(1, 0, ra(0, 0), 16'h1234, 0);
        bus_op(1, 1, ra(0, 0), 16'hBEEF, 16'h1234);
        bus_op(0, 1, ra(0, 0), 0, 16'hBEEF);
        cycles(1);

        // Reset during an outstanding read, bit0 held high throughout.
        pin_in = 48'h1;
        addr   = ra(1, 0);
        rd_en  = 1'b1;
        #2;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check("rst_rd_valid_low", PW'(rd_valid), '0);
        check("rst_irq_low", PW'(irq), '0);
        check("rst_pin_out", pin_out, '0);
        check("rst_pin_oe", pin_oe, '0);
        cycles(1);
        @(negedge clk);
        rst_n = 1'b1;
        bus_op(1, 0, ra(0, 5), 16'h0001, 0);
        bus_op(1, 0, ra(0, 3), 16'h0001, 0);
        check("post_rst_irq_r2", PW'(irq), '0);
        cycles(1);
        check("post_rst_irq_r3", PW'(irq), '0);
        cycles(1);
        check("post_rst_irq_r4", PW'(irq), 1);
        bus_op(0, 1, ra(0, 4), 0, 16'h0001);
        bus_op(0, 1, ra(1, 0), 0, 16'h0000);
        bus_op(0, 1, ra(1, 1), 0, 16'h0000);
        bus_op(0, 1, ra(0, 0), 0, 16'h0000);
        bus_op(0, 1, ra(2, 3), 0, 16'h0000);
        cycles(2);
        check("scoreboard_drained", PW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
